// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the matrix row reader and its return FIFO.
package matrix_pkg;

   // Reader command phases: waiting, sending row requests, waiting for the last pop.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } row_reader_state_t;

   // Bits needed to address n entries; never less than one bit.
   function automatic int addr_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Bits needed to hold a count from 0 up to and including n.
   function automatic int count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/matrix_row_reader_fifo.sv
// Show-ahead FIFO: the head entry is presented on data_out whenever empty=0.
// Storage is register based and cleared by reset so data_out reads 0 after reset.
module fifo_show_ahead
   import matrix_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int PTR_W = addr_width(DEPTH),
   localparam int CNT_W = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with wrap at the last entry (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign data_out = mem[rd_ptr];

   // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine if it pops too.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Storage, pointers and occupancy; simultaneous push and pop are both performed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/matrix_row_reader.sv
// Read-side initiator for the matrix storage block. Sweeps a wrapping range of
// row addresses into the non-stallable matrix read port and streams the returned
// rows, in order, to a downstream stage.
//
// Output handshake: a row transfers in every cycle where out_valid and out_ready
// are both high. out_valid never drops without a transfer, and out_data,
// out_index and out_last stay stable from the rise of out_valid until the transfer.
//
// Credits (requests in flight plus rows buffered) are capped at FIFO_DEPTH, so
// every row the matrix returns always has a FIFO slot waiting for it.
module matrix_row_reader
   import matrix_pkg::*;
#(
   parameter  int NUM_ROWS       = 3,
   parameter  int NUM_COLS       = 5,
   parameter  int SCALAR_BITS    = 32,
   parameter  int MEMORY_LATENCY = 2,
   parameter  int FIFO_DEPTH     = MEMORY_LATENCY + 1,
   localparam int ROW_ADDR_WIDTH = addr_width(NUM_ROWS),
   localparam int CNT_WIDTH      = count_width(NUM_ROWS),
   localparam int ROW_SIZE       = NUM_COLS * SCALAR_BITS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ROW_ADDR_WIDTH-1:0] first_row,
   input  logic [CNT_WIDTH-1:0]      row_count,
   output logic                      busy,
   output logic                      done,
   output logic [ROW_ADDR_WIDTH-1:0] row_addr,
   output logic                      row_addr_ready,
   input  logic                      row_valid,
   input  logic [ROW_SIZE-1:0]       row_out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ROW_SIZE-1:0]       out_data,
   output logic [ROW_ADDR_WIDTH-1:0] out_index,
   output logic                      out_last,
   output logic [1:0]                fsm_state
);

   // A request returns exactly MEMORY_LATENCY cycles after issue, so at most that many are in flight.
   localparam int FLIGHT_W   = count_width(MEMORY_LATENCY);
   localparam int FIFO_CNT_W = count_width(FIFO_DEPTH);
   localparam int CRED_W     = count_width(FIFO_DEPTH + MEMORY_LATENCY);

   row_reader_state_t state;
   row_reader_state_t next_state;

   logic [ROW_ADDR_WIDTH-1:0] issue_addr;
   logic [CNT_WIDTH-1:0]      issue_rem;
   logic [CNT_WIDTH-1:0]      pop_rem;
   logic [FLIGHT_W-1:0]       in_flight;
   logic                      done_q;

   logic [CNT_WIDTH-1:0]      count_clamped;
   logic [CRED_W-1:0]         credits;
   logic                      accept;
   logic                      credit_ok;
   logic                      issue;
   logic                      pop;
   logic                      push;
   logic                      finish;

   logic                      fifo_empty;
   logic                      fifo_full;
   logic [FIFO_CNT_W-1:0]     fifo_count;

   // Row numbers wrap from NUM_ROWS-1 back to 0.
   function automatic logic [ROW_ADDR_WIDTH-1:0] next_row(input logic [ROW_ADDR_WIDTH-1:0] r);
      return (r == ROW_ADDR_WIDTH'(NUM_ROWS - 1)) ? '0 : r + ROW_ADDR_WIDTH'(1);
   endfunction

   assign count_clamped = (row_count > CNT_WIDTH'(NUM_ROWS)) ? CNT_WIDTH'(NUM_ROWS) : row_count;
   assign accept        = (state == IDLE) & start;

   // Buffered rows already count against the budget, and a same-cycle pop frees one credit.
   assign credits   = CRED_W'(in_flight) + CRED_W'(fifo_count);
   assign pop       = out_valid & out_ready;
   assign credit_ok = (credits < CRED_W'(FIFO_DEPTH)) | pop;
   assign issue     = (state == ISSUE) & credit_ok;

   // Returns with nothing outstanding are spurious and dropped; the full guard is belt-and-braces.
   assign push = row_valid & (in_flight != '0) & (~fifo_full | pop);

   assign row_addr_ready = issue;
   assign row_addr       = issue_addr;
   assign out_valid      = ~fifo_empty;
   assign out_last       = out_valid & (pop_rem == CNT_WIDTH'(1));
   assign done           = done_q;
   assign busy           = (state != IDLE) & ~done_q;
   assign fsm_state      = state;

   fifo_show_ahead #(
      .WIDTH (ROW_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .data_in  (row_out),
      .data_out (out_data),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state; finish marks the edge after which done pulses for one cycle.
   always_comb begin
      next_state = state;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (count_clamped == '0) begin
                  next_state = DRAIN;
                  finish     = 1'b1;
               end else begin
                  next_state = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (issue && (issue_rem == CNT_WIDTH'(1))) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            // An empty command passes straight through; otherwise leave on the final pop.
            if (pop_rem == '0) begin
               next_state = IDLE;
            end else if (pop && (pop_rem == CNT_WIDTH'(1))) begin
               next_state = IDLE;
               finish     = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Command registers: addresses, output index and remaining-row counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_addr <= '0;
         out_index  <= '0;
         issue_rem  <= '0;
         pop_rem    <= '0;
      end else if (accept) begin
         issue_addr <= first_row;
         out_index  <= first_row;
         issue_rem  <= count_clamped;
         pop_rem    <= count_clamped;
      end else begin
         if (issue) begin
            issue_addr <= next_row(issue_addr);
            issue_rem  <= issue_rem - CNT_WIDTH'(1);
         end
         if (pop) begin
            out_index <= next_row(out_index);
            pop_rem   <= pop_rem - CNT_WIDTH'(1);
         end
      end
   end

   // Requests in flight: up on issue, down when the matrix returns a row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_flight <= '0;
      end else begin
         case ({issue, push})
            2'b10:   in_flight <= in_flight + FLIGHT_W'(1);
            2'b01:   in_flight <= in_flight - FLIGHT_W'(1);
            default: in_flight <= in_flight;
         endcase
      end
   end

   // Completion pulse, registered so it coincides with the return to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= finish;
      end
   end

endmodule

// File: tb/tb_matrix_row_reader.sv
// Directed bench for matrix_row_reader with a behavioural matrix (A[r][c] = 16r + c).
module tb_matrix_row_reader;

   localparam int NR = 4;
   localparam int NC = 2;
   localparam int SB = 8;
   localparam int ML = 2;
   localparam int FD = 3;
   localparam int AW = 2;
   localparam int CW = 3;
   localparam int RS = NC * SB;
   localparam int EW = 1 + AW + RS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic          start = 1'b0;
   logic [AW-1:0] first_row = '0;
   logic [CW-1:0] row_count = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] row_addr;
   logic          row_addr_ready;
   logic          row_valid;
   logic [RS-1:0] row_out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [RS-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic [1:0]    fsm_state;

   matrix_row_reader #(
      .NUM_ROWS       (NR),
      .NUM_COLS       (NC),
      .SCALAR_BITS    (SB),
      .MEMORY_LATENCY (ML),
      .FIFO_DEPTH     (FD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .first_row      (first_row),
      .row_count      (row_count),
      .busy           (busy),
      .done           (done),
      .row_addr       (row_addr),
      .row_addr_ready (row_addr_ready),
      .row_valid      (row_valid),
      .row_out        (row_out),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_index      (out_index),
      .out_last       (out_last),
      .fsm_state      (fsm_state)
   );

   // ---------------- matrix model ----------------
   function automatic logic [RS-1:0] mat_row(input int r);
      logic [7:0] c0;
      logic [7:0] c1;
      c0 = 8'(16 * r);
      c1 = 8'(16 * r + 1);
      return {c1, c0};
   endfunction

   logic          m_vld [ML];
   logic [AW-1:0] m_adr [ML];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ML; i++) begin
            m_vld[i] <= 1'b0;
            m_adr[i] <= '0;
         end
      end else begin
         m_vld[0] <= row_addr_ready;
         m_adr[0] <= row_addr;
         for (int i = 1; i < ML; i++) begin
            m_vld[i] <= m_vld[i-1];
            m_adr[i] <= m_adr[i-1];
         end
      end
   end

   assign row_valid = m_vld[ML-1];
   assign row_out   = m_vld[ML-1] ? mat_row(int'(m_adr[ML-1])) : '0;

   // ---------------- scoreboard / bookkeeping ----------------
   logic [EW-1:0] exp_q[$];
   int issue_cyc[$];
   int issue_adr[$];
   int pop_cyc[$];
   int pop_idx[$];
   int last_cyc[$];
   int last_idx[$];
   int done_cyc[$];
   int t0 = 0;
   int outstanding = 0;
   int max_out = 0;
   int valid_cnt = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit rand_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
      n_tests++;
      if (got !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
      end
   endtask

   task automatic check_q(input string tag, input int got[$], input int expected[$]);
      check({tag, "_len"}, 32'(got.size()), 32'(expected.size()));
      for (int i = 0; i < expected.size(); i++) begin
         check(tag, (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff, 32'(expected[i]));
      end
   endtask

   // Monitor: logs requests, pops and done relative to the last accepted start; checks rows.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         outstanding = 0;
      end else begin
         if (row_addr_ready) begin
            issue_cyc.push_back(cyc - t0);
            issue_adr.push_back(int'(row_addr));
            outstanding++;
         end
         if (out_valid) valid_cnt++;
         if (out_valid && out_ready) begin
            pop_cyc.push_back(cyc - t0);
            pop_idx.push_back(int'(out_index));
            outstanding--;
            if (out_last) begin
               last_cyc.push_back(cyc - t0);
               last_idx.push_back(int'(out_index));
            end
            if (exp_q.size() == 0) check("sb_unexpected_row", 32'(exp_q.size()), 32'd1);
            else check("sb_row", 32'({out_last, out_index, out_data}), 32'(exp_q.pop_front()));
         end
         if (done) done_cyc.push_back(cyc - t0);
         if (outstanding > max_out) max_out = outstanding;
      end
   end

   // Random backpressure for the soak phase.
   initial forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      issue_cyc.delete();
      issue_adr.delete();
      pop_cyc.delete();
      pop_idx.delete();
      last_cyc.delete();
      last_idx.delete();
      done_cyc.delete();
      valid_cnt = 0;
      max_out   = 0;
   endtask

   // Queues the expected rows, then holds start for one cycle (cycle 0 of the command).
   task automatic send_cmd(input logic [AW-1:0] fr, input logic [CW-1:0] cnt);
      int n;
      int r;
      n = (int'(cnt) > NR) ? NR : int'(cnt);
      for (int i = 0; i < n; i++) begin
         r = (int'(fr) + i) % NR;
         exp_q.push_back({(i == n - 1), 2'(r), mat_row(r)});
      end
      @(posedge clk);
      #1;
      t0        = cyc;
      start     = 1'b1;
      first_row = fr;
      row_count = cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({fsm_state, busy, done, row_addr_ready, out_valid, out_last, row_addr, out_index, out_data});
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      #2;
      check("reset_outputs", out_vec(), 32'd0);
      #15;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_outputs", out_vec(), 32'd0);

      // 1: full sweep, no backpressure
      out_ready = 1'b1;
      clear_logs();
      send_cmd(2'd0, 3'd4);
      wait_done(40);
      check_q("t1_issue_cyc", issue_cyc, '{1, 2, 3, 4});
      check_q("t1_addr", issue_adr, '{0, 1, 2, 3});
      check_q("t1_pop_cyc", pop_cyc, '{4, 5, 6, 7});
      check_q("t1_last_cyc", last_cyc, '{7});
      check_q("t1_done_cyc", done_cyc, '{8});
      check("t1_busy_after", 32'(busy), 32'd0);

      // 2: stalled consumer limits requests to the FIFO depth
      out_ready = 1'b0;
      clear_logs();
      send_cmd(2'd0, 3'd4);
      repeat (8) @(negedge clk);
      check("t2_issued", 32'(issue_cyc.size()), 32'd3);
      check("t2_req_low", 32'(row_addr_ready), 32'd0);
      check("t2_no_pop", 32'(pop_cyc.size()), 32'd0);
      check("t2_valid_held", 32'(out_valid), 32'd1);
      check("t2_max_credits", 32'(max_out), 32'd3);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_done(40);
      check_q("t2_addr", issue_adr, '{0, 1, 2, 3});
      check_q("t2_idx", pop_idx, '{0, 1, 2, 3});
      check("t2_exp_empty", 32'(exp_q.size()), 32'd0);

      // 3: wrapping range
      clear_logs();
      send_cmd(2'd3, 3'd3);
      wait_done(40);
      check_q("t3_addr", issue_adr, '{3, 0, 1});
      check_q("t3_idx", pop_idx, '{3, 0, 1});
      check_q("t3_last_idx", last_idx, '{1});

      // 4a: empty command
      clear_logs();
      send_cmd(2'd1, 3'd0);
      wait_done(10);
      repeat (5) @(negedge clk);
      check_q("t4_done_cyc", done_cyc, '{1});
      check("t4_no_req", 32'(issue_cyc.size()), 32'd0);
      check("t4_no_valid", 32'(valid_cnt), 32'd0);

      // 4b: start while busy is ignored
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      clear_logs();
      send_cmd(2'd0, 3'd2);
      repeat (3) @(posedge clk);
      #1;
      check("t4_busy", 32'(busy), 32'd1);
      start     = 1'b1;
      first_row = 2'd2;
      row_count = 3'd3;
      @(posedge clk);
      #1;
      start     = 1'b0;
      out_ready = 1'b1;
      wait_done(40);
      repeat (6) @(negedge clk);
      check_q("t4_addr", issue_adr, '{0, 1});
      check("t4_exp_empty", 32'(exp_q.size()), 32'd0);
      check("t4_idle", 32'(busy), 32'd0);

      // 5: asynchronous reset mid-issue
      @(posedge clk);
      #1;
      clear_logs();
      send_cmd(2'd0, 3'd4);
      repeat (3) @(posedge clk);
      #2;
      check("t5_valid_before", 32'(out_valid), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("t5_reset_outputs", out_vec(), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_logs();
      send_cmd(2'd2, 3'd2);
      wait_done(40);
      check_q("t5_addr", issue_adr, '{2, 3});
      check_q("t5_idx", pop_idx, '{2, 3});
      check("t5_exp_empty", 32'(exp_q.size()), 32'd0);

      // 6: random backpressure soak, including counts above NUM_ROWS
      clear_logs();
      rand_ready = 1'b1;
      for (int k = 0; k < 200; k++) begin
         send_cmd(2'($urandom_range(0, NR - 1)), 3'($urandom_range(0, 6)));
         wait_done(200);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      check("t6_exp_empty", 32'(exp_q.size()), 32'd0);
      check("t6_max_credits", 32'(max_out), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/matrix_row_reader.md
# matrix_row_reader

Read-side initiator for the dual-port `matrix` storage block. On a start command it sweeps a contiguous, wrapping range of row addresses into the matrix row-read port, then collects the rows returned after `MEMORY_LATENCY` cycles. It delivers them, in order, on a valid/ready stream towards the downstream compute stage. A credit counter and an internal show-ahead FIFO make the block tolerate arbitrary downstream backpressure without losing rows, since the matrix read port itself cannot be stalled.

## Interface
Parameters:
- `NUM_ROWS`, 3: rows of the attached matrix; must be ≥2.
- `NUM_COLS`, 5: columns of the attached matrix.
- `SCALAR_BITS`, 32: bits per scalar.
- `MEMORY_LATENCY`, 2: matrix read latency in cycles; must be ≥1.
- `FIFO_DEPTH`, `MEMORY_LATENCY+1`: return-buffer entries. Must be ≥1; ≥`MEMORY_LATENCY+1` gives one row per cycle.
- Derived values (not overridable): `ROW_ADDR_WIDTH=$clog2(NUM_ROWS)`, `CNT_WIDTH=$clog2(NUM_ROWS+1)`, `ROW_SIZE=NUM_COLS*SCALAR_BITS`.

Ports:
- `clk`  in  1  the single clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous assertion, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `first_row`  in  `ROW_ADDR_WIDTH`  first row to read; must be < `NUM_ROWS`.
- `row_count`  in  `CNT_WIDTH`  rows to read, 0..`NUM_ROWS`.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when the command completes.
- `row_addr`  out  `ROW_ADDR_WIDTH`  connects to the matrix `row_addr`.
- `row_addr_ready`  out  1  request strobe; connects to the matrix `row_addr_ready`.
- `row_valid`  in  1  from the matrix.
- `row_out`  in  `ROW_SIZE`  from the matrix.
- `out_valid`  out  1  an output row is available.
- `out_ready`  in  1  downstream accepts the row.
- `out_data`  out  `ROW_SIZE`  row data; scalar c is at bits [(c+1)*SCALAR_BITS-1 : c*SCALAR_BITS].
- `out_index`  out  `ROW_ADDR_WIDTH`  row number of `out_data`.
- `out_last`  out  1  marks the final row of the command.

## Operation
- States are IDLE, ISSUE and DRAIN.
- **IDLE**, with `start=1`:
  - Latch `first_row` and `row_count`.
  - Load the issue address, the output index (both = `first_row`) and the issue/pop remaining counters (both = `row_count`).
  - Go to ISSUE, or to DRAIN if `row_count=0`.
- **ISSUE**: each cycle, issue when `credits - pop < FIFO_DEPTH`, where `credits` = requests in flight + FIFO occupancy, and `pop = out_valid & out_ready`.
  - An issue drives `row_addr_ready=1` with `row_addr` = the current address.
  - The address increments and wraps from `NUM_ROWS-1` to 0.
  - The issue-remaining counter decrements; the block moves to DRAIN on the last issue.
- **DRAIN**: when the pop-remaining counter is 0, pulse `done`, drop `busy` and return to IDLE.
- Credits increment on an issue and decrement on a pop. A simultaneous issue and pop leaves the count unchanged.
- `row_valid` pushes `row_out` into the FIFO. `row_valid` with zero requests in flight is dropped.
- The FIFO cannot overflow, by the credit rule.
- `out_index` starts at `first_row` and increments with wrap on each pop.
- `out_last = out_valid` and pop-remaining = 1.
- `start` outside IDLE is ignored.
- `row_count > NUM_ROWS` is clamped to `NUM_ROWS`.

## Timing
- Every register, including FIFO storage, resets to 0 asynchronously while `rst=0`. All outputs are therefore 0 during and after reset.
- The matrix shares `rst`, so in-flight returns are flushed with it.
- With `start` accepted in cycle 0:
  - the first `row_addr_ready` is in cycle 1;
  - the row returns in cycle 1+`MEMORY_LATENCY`;
  - `out_valid` is first high in cycle 2+`MEMORY_LATENCY`.
- The FIFO is show-ahead: `out_data`, `out_index` and `out_last` are registered and valid whenever `out_valid=1`.
- Once `out_valid` rises, `out_data`, `out_index` and `out_last` are held stable until the pop.
- Full/empty:
  - A push to an empty FIFO is visible the next cycle.
  - A push and a pop in the same cycle are both performed.
- `done` and `busy=0` appear in the cycle after the final pop.
- A new start can be accepted in the same cycle as `done`, since the state is IDLE.
- `row_count=0`: `done` pulses in cycle 1, with no requests and no output.

## Structure
- Package `matrix_pkg`: the `row_reader_state_t` enum {IDLE, ISSUE, DRAIN} and the width helper functions.
- Sub-module `fifo_show_ahead`:
  - parameters `WIDTH`, `DEPTH`;
  - ports: push, pop, data in/out, empty, full, count;
  - resettable storage.
- The payload is `{out_data}` only. `out_index` and `out_last` come from the reader's own counters.

## Test plan
Common setup: `NUM_ROWS=4`, `NUM_COLS=2`, `SCALAR_BITS=8`, `MEMORY_LATENCY=2`, `FIFO_DEPTH=3`. Matrix loaded with A[r][c]=16r+c.
1. `first_row=0`, `row_count=4`, `out_ready=1` -> `row_addr` 0,1,2,3 in cycles 1–4; out rows `out_data` 0x01,0x00 … 0x31,0x30 in cycles 4–7; `out_last` in cycle 7; `done` in cycle 8.
2. `out_ready=0` -> exactly 3 requests issued, `row_addr_ready` stays low. Then `out_ready=1` -> remaining row issued, rows 0..3 delivered in order, none lost.
3. `first_row=3`, `row_count=3` -> addresses 3,0,1; `out_index` 3,0,1; `out_last` with index 1.
4. `row_count=0` -> `done` in cycle 1, `row_addr_ready` and `out_valid` never high. `start` pulsed while `busy` -> ignored, output unchanged.
5. `rst` low mid-ISSUE -> all outputs 0 immediately. After release, `first_row=2`, `row_count=2` -> rows 2,3 correct.
6. Random `out_ready` (50%) over 200 commands -> scoreboard matches A, order kept, credits never exceed 3.
